msk_encoder: RTL and testbench
==============================

MSK_ENCODER -- requirements
Module: msk_encoder

Interface
REQ-001 Parameter: d, default 2, number of Boolean shares per bit; legal range d >= 2.
REQ-002 The block SHALL have these ports, with d = parameter d:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset.
- in_valid  input  1  plaintext word offered.
- in_data  input  32  plaintext word.
- in_ready  output  1  word accepted this cycle when in_valid also high.
- rnd_valid  input  1  fresh randomness available.
- rnd  input  32*(d-1)  random bits for one word; bits [32*(j+1)-1:32*j] form share j.
- rnd_ready  output  1  rnd consumed this cycle.
- flush  input  1  synchronous abort of a partially loaded block.
- msk_out  output  128*d  masked block; shares of bit o occupy [d*(o+1)-1:d*o].
- out_valid  output  1  msk_out holds a complete masked block.
- out_ready  input  1  consumer accepts msk_out.

Function
REQ-003 The block SHALL have two states, LOAD and HOLD, and a 2-bit word counter wcnt.
REQ-004 in_ready SHALL equal (state==LOAD) AND rnd_valid, combinationally.
REQ-005 A word SHALL be accepted on a rising edge with in_valid AND in_ready; rnd_ready SHALL be high in that same cycle.
REQ-006 Accepted word k (k = wcnt) SHALL map to plaintext bits [127-32k:96-32k], i.e. the first word is most significant.
REQ-007 For each bit of an accepted word: share j (j = 0..d-2) SHALL be the matching rnd bit; share d-1 SHALL be the data bit XOR all d-1 random bits.
REQ-008 Only the 32*d msk_out bits of the accepted word SHALL change; all others SHALL hold.
REQ-009 wcnt SHALL increment on each acceptance and wrap 3 -> 0.
REQ-010 On the 4th acceptance the state SHALL become HOLD, with out_valid high from the next cycle.
REQ-011 Latency: 1 cycle from the 4th word edge to out_valid.
REQ-012 In HOLD: out_valid SHALL stay high and in_ready SHALL stay low until out_valid AND out_ready on an edge, which SHALL return the state to LOAD with wcnt=0.
REQ-013 A new block's words SHALL NOT be accepted in the handshake cycle; the first new word is accepted the cycle after.
REQ-014 XOR of the d shares of every bit of msk_out SHALL equal the loaded plaintext bit whenever out_valid is high.
REQ-015 flush in LOAD SHALL clear wcnt to 0 and block word acceptance that cycle; msk_out is not cleared.
REQ-016 flush in HOLD SHALL be ignored.
REQ-017 rnd_valid low in LOAD SHALL stall loading with no state change, even if in_valid is high.

Reset
REQ-018 While reset is low: state=LOAD, wcnt=0, msk_out all zeros, out_valid=0.
REQ-019 While reset is low, in_ready and rnd_ready SHALL be 0.
REQ-020 Reset asserted mid-block or in HOLD SHALL discard the block immediately and asynchronously.

Configuration
REQ-021 Macro MSK_REFRESH_EN, defined: in HOLD, each cycle with rnd_valid high and no handshake, one word's shares SHALL be refreshed.
- Word selection: round-robin pointer, 0..3, wrapping; the pointer resets to 0 on entry to HOLD.
- Refresh: share j ^= rnd share j for j <= d-2; share d-1 ^= XOR of those rnd bits.
- rnd_ready SHALL be high in refresh cycles.
- The recombined value SHALL remain unchanged.
REQ-022 Macro undefined: msk_out SHALL be stable throughout HOLD, and rnd_ready SHALL be 0 in HOLD.

Verification
REQ-023 Basic load, d=2, rnd all ones: words a42757d2, ace7ce85, 8ba9b1a3, 215a899d.
- out_valid rises 1 cycle after the 4th word.
- share0 = all ones; share1 = 5bd8a82d53183 17a74564e5cdea5766 2.
- Recombined value = a42757d2ace7ce858ba9b1a3215a899d.
REQ-024 Stalls: toggle rnd_valid low for 3 cycles between words -> no acceptance while low; same final recombined value.
REQ-025 Flush: flush after 2 words, then load 4 words of 0x00000000 -> recombined value 0; out_valid only after 4 post-flush words.
REQ-026 Back-pressure: hold out_ready low 10 cycles, then high.
- in_ready stays 0 throughout; handshake occurs on the first high edge.
- Next block loads from the following cycle.
REQ-027 Reset: reset low after word 3 -> out_valid=0, msk_out=0, wcnt=0; a full reload produces the correct result.
REQ-028 Refresh, MSK_REFRESH_EN defined, d=3, random rnd, out_ready low 8 cycles:
- msk_out changes each cycle.
- Recombined value equals the plaintext every cycle.

Source files
------------

// File: rtl/msk_encoder.sv
// msk_encoder: loads four 32-bit words into a d-share Boolean-masked 128-bit block.
// Defining MSK_REFRESH_EN enables round-robin share refresh while a block is held.
module msk_encoder #(
    parameter int d = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    output logic                  in_ready,
    input  logic                  rnd_valid,
    input  logic [32*(d-1)-1:0]   rnd,
    output logic                  rnd_ready,
    input  logic                  flush,
    output logic [128*d-1:0]      msk_out,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int WordW = 32 * d;

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       wcnt_q, wcnt_d;
    logic [128*d-1:0] msk_q, msk_d;

    logic [WordW-1:0] rndMask;
    logic [WordW-1:0] encWord;
    logic [31:0]      rndPar;
    logic [1:0]       loadSlot;
    logic             accept;
    logic             handshake;

    // The first loaded word lands in the most significant slot.
    assign loadSlot = 2'd3 - wcnt_q;

    // rndMask carries the random shares plus their parity on the last share, so
    // it serves both as the encoding mask and as a recombination-neutral refresh.
    always_comb begin
        rndMask = '0;
        rndPar  = '0;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < d - 1; j++) begin
                rndMask[d*i+j] = rnd[32*j+i];
                rndPar[i]      = rndPar[i] ^ rnd[32*j+i];
            end
            rndMask[d*i+d-1] = rndPar[i];
        end
        encWord = rndMask;
        for (int i = 0; i < 32; i++) begin
            encWord[d*i+d-1] = rndPar[i] ^ in_data[i];
        end
    end

    assign in_ready  = reset & (state_q == LOAD) & rnd_valid;
    assign accept    = in_valid & in_ready & ~flush;
    assign out_valid = (state_q == HOLD);
    assign handshake = out_valid & out_ready;
    assign msk_out   = msk_q;

`ifdef MSK_REFRESH_EN
    logic [1:0] rptr_q, rptr_d;
    logic [1:0] refreshSlot;
    logic       refresh;

    assign refreshSlot = 2'd3 - rptr_q;
    assign refresh     = reset & (state_q == HOLD) & rnd_valid & ~handshake;
    assign rnd_ready   = accept | refresh;
`else
    assign rnd_ready   = accept;
`endif

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        msk_d   = msk_q;
`ifdef MSK_REFRESH_EN
        rptr_d  = rptr_q;
`endif
        case (state_q)
            LOAD: begin
                if (flush) begin
                    wcnt_d = '0;
                end else if (accept) begin
                    msk_d[WordW*int'(loadSlot) +: WordW] = encWord;
                    wcnt_d = wcnt_q + 2'd1;
                    if (wcnt_q == 2'd3) begin
                        state_d = HOLD;
`ifdef MSK_REFRESH_EN
                        rptr_d  = '0;
`endif
                    end
                end
            end
            HOLD: begin
                if (handshake) begin
                    state_d = LOAD;
                    wcnt_d  = '0;
                end
`ifdef MSK_REFRESH_EN
                else if (refresh) begin
                    msk_d[WordW*int'(refreshSlot) +: WordW] =
                        msk_q[WordW*int'(refreshSlot) +: WordW] ^ rndMask;
                    rptr_d = rptr_q + 2'd1;
                end
`endif
            end
            default: begin
                state_d = LOAD;
                wcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD;
            wcnt_q  <= '0;
            msk_q   <= '0;
`ifdef MSK_REFRESH_EN
            rptr_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            msk_q   <= msk_d;
`ifdef MSK_REFRESH_EN
            rptr_q  <= rptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_msk_encoder.sv
// Directed testbench for msk_encoder; d=2 by default, d=3 when MSK_REFRESH_EN is defined.
module tb_msk_encoder;

`ifdef MSK_REFRESH_EN
    localparam int D = 3;
`else
    localparam int D = 2;
`endif
    localparam int WW = 32 * D;
    localparam int RW = 32 * (D - 1);

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [31:0]     in_data;
    logic            in_ready;
    logic            rnd_valid;
    logic [RW-1:0]   rnd;
    logic            rnd_ready;
    logic            flush;
    logic [128*D-1:0] msk_out;
    logic            out_valid;
    logic            out_ready;

    int total = 0;
    int bad   = 0;

    logic [128*D-1:0] model;
    int               kModel;

    always #5 clk = ~clk;

    msk_encoder #(.d(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rnd_valid (rnd_valid),
        .rnd       (rnd),
        .rnd_ready (rnd_ready),
        .flush     (flush),
        .msk_out   (msk_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic logic [127:0] recombine(input logic [128*D-1:0] m);
        logic [127:0] r;
        r = '0;
        for (int o = 0; o < 128; o++)
            for (int s = 0; s < D; s++)
                r[o] = r[o] ^ m[D*o+s];
        return r;
    endfunction

    function automatic logic [127:0] shareOf(input logic [128*D-1:0] m, input int s);
        logic [127:0] r;
        for (int o = 0; o < 128; o++) r[o] = m[D*o+s];
        return r;
    endfunction

    function automatic logic [WW-1:0] encode(input logic [31:0] data, input logic [RW-1:0] rv);
        logic [WW-1:0] w;
        logic p;
        w = '0;
        for (int i = 0; i < 32; i++) begin
            p = data[i];
            for (int j = 0; j < D - 1; j++) begin
                w[D*i+j] = rv[32*j+i];
                p = p ^ rv[32*j+i];
            end
            w[D*i+D-1] = p;
        end
        return w;
    endfunction

    function automatic logic [RW-1:0] fillRnd(input logic [31:0] pat);
        logic [RW-1:0] rv;
        for (int j = 0; j < D - 1; j++) rv[32*j +: 32] = pat ^ (32'h9e3779b9 * j);
        return rv;
    endfunction

    task automatic loadWord(input logic [31:0] data, input logic [RW-1:0] rv);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = data;
        rnd_valid = 1'b1;
        rnd       = rv;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        rnd_valid = 1'b0;
        model[WW*(3-kModel) +: WW] = encode(data, rv);
        kModel = (kModel + 1) % 4;
    endtask

    task automatic doHandshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        kModel = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 32'hcafef00d; rnd_valid = 1'b1;
        rnd = '1; flush = 1'b0; out_ready = 1'b0;
        #1 reset = 1'b0;
        #11;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        total++; if (rnd_ready !== 1'b0) begin bad++; $display("FAIL reset_rnd_ready got=%b want=0", rnd_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (msk_out !== '0) begin bad++; $display("FAIL reset_msk_out got=%h want=0", msk_out); end
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; rnd_valid = 1'b0;
        model = '0; kModel = 0;
    endtask

    task automatic test_basic_load();
        logic [127:0] plain = 128'ha42757d2ace7ce858ba9b1a3215a899d;
        logic [127:0] lastExp;
        loadWord(32'ha42757d2, '1);
        total++; if (msk_out !== model) begin bad++; $display("FAIL basic_word0_only got=%h want=%h", msk_out, model); end
        loadWord(32'hace7ce85, '1);
        loadWord(32'h8ba9b1a3, '1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_early got=%b want=0", out_valid); end
        loadWord(32'h215a899d, '1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid_latency got=%b want=1", out_valid); end
        total++; if (msk_out !== model) begin bad++; $display("FAIL basic_msk got=%h want=%h", msk_out, model); end
        total++; if (recombine(msk_out) !== plain) begin bad++; $display("FAIL basic_recomb got=%h want=%h", recombine(msk_out), plain); end
        total++; if (shareOf(msk_out, 0) !== '1) begin bad++; $display("FAIL basic_share0 got=%h want=all ones", shareOf(msk_out, 0)); end
        lastExp = ((D % 2) == 0) ? 128'h5bd8a82d5318317a74564e5cdea57662 : plain;
        total++; if (shareOf(msk_out, D-1) !== lastExp) begin bad++; $display("FAIL basic_share_last got=%h want=%h", shareOf(msk_out, D-1), lastExp); end
        @(negedge clk);
        in_valid = 1'b1; rnd_valid = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_hold_in_ready got=%b want=0", in_ready); end
        in_valid = 1'b0; rnd_valid = 1'b0;
        doHandshake();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_handshake got=%b want=0", out_valid); end
    endtask

    task automatic test_stall();
        logic [127:0] plain = 128'ha42757d2ace7ce858ba9b1a3215a899d;
        loadWord(32'ha42757d2, fillRnd(32'h3c5a9617));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 32'h77777777; rnd_valid = 1'b0;
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready c=%0d got=%b want=0", c, in_ready); end
            @(posedge clk);
            #1;
            total++; if (msk_out !== model) begin bad++; $display("FAIL stall_hold c=%0d got=%h want=%h", c, msk_out, model); end
        end
        in_valid = 1'b0;
        loadWord(32'hace7ce85, fillRnd(32'h0f1e2d3c));
        loadWord(32'h8ba9b1a3, fillRnd(32'hdeadbeef));
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_valid_early got=%b want=0", out_valid); end
        loadWord(32'h215a899d, fillRnd(32'h13572468));
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b want=1", out_valid); end
        total++; if (msk_out !== model) begin bad++; $display("FAIL stall_msk got=%h want=%h", msk_out, model); end
        total++; if (recombine(msk_out) !== plain) begin bad++; $display("FAIL stall_recomb got=%h want=%h", recombine(msk_out), plain); end
        doHandshake();
    endtask

    task automatic test_flush();
        loadWord(32'hdeadbeef, fillRnd(32'h11111111));
        loadWord(32'h12345678, fillRnd(32'h22222222));
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hffffffff; rnd_valid = 1'b1; rnd = fillRnd(32'h33333333);
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0;
        kModel = 0;
        total++; if (msk_out !== model) begin bad++; $display("FAIL flush_no_write got=%h want=%h", msk_out, model); end
        loadWord(32'h0, fillRnd(32'ha5a5a5a5));
        loadWord(32'h0, fillRnd(32'h5a5a5a5a));
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid_2 got=%b want=0", out_valid); end
        loadWord(32'h0, fillRnd(32'hc3c3c3c3));
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid_3 got=%b want=0", out_valid); end
        loadWord(32'h0, fillRnd(32'h0ff00ff0));
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_valid_4 got=%b want=1", out_valid); end
        total++; if (recombine(msk_out) !== 128'h0) begin bad++; $display("FAIL flush_recomb got=%h want=0", recombine(msk_out)); end
        total++; if (msk_out !== model) begin bad++; $display("FAIL flush_msk got=%h want=%h", msk_out, model); end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_in_hold got=%b want=1", out_valid); end
        doHandshake();
    endtask

    task automatic test_back_to_back();
        logic [127:0] plain = 128'h0123456789abcdeffedcba9876543210;
        logic [127:0] plain2 = 128'h55aa55aa0000ffff12121212f0e1d2c3;
        logic [RW-1:0] rvB = fillRnd(32'h6b8b4567);
        loadWord(32'h01234567, fillRnd(32'h327b23c6));
        loadWord(32'h89abcdef, fillRnd(32'h643c9869));
        loadWord(32'hfedcba98, fillRnd(32'h66334873));
        loadWord(32'h76543210, fillRnd(32'h74b0dc51));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55aa55aa; rnd_valid = 1'b1; rnd = rvB;
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c=%0d got=%b want=0", c, in_ready); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid c=%0d got=%b want=1", c, out_valid); end
            @(posedge clk);
        end
        #1;
        total++; if (recombine(msk_out) !== plain) begin bad++; $display("FAIL bp_recomb got=%h want=%h", recombine(msk_out), plain); end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hs_in_ready got=%b want=0", in_ready); end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        kModel = 0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_handshake got=%b want=0", out_valid); end
        @(negedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_next_ready got=%b want=1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0; rnd_valid = 1'b0;
        model[WW*3 +: WW] = encode(32'h55aa55aa, rvB);
        kModel = 1;
        total++; if (msk_out[WW*3 +: WW] !== model[WW*3 +: WW]) begin bad++; $display("FAIL bp_first_word got=%h want=%h", msk_out[WW*3 +: WW], model[WW*3 +: WW]); end
        loadWord(32'h0000ffff, fillRnd(32'h2ae8944a));
        loadWord(32'h12121212, fillRnd(32'h625558ec));
        loadWord(32'hf0e1d2c3, fillRnd(32'h238e1f29));
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_second_valid got=%b want=1", out_valid); end
        total++; if (recombine(msk_out) !== plain2) begin bad++; $display("FAIL bp_second_recomb got=%h want=%h", recombine(msk_out), plain2); end
        doHandshake();
    endtask

    task automatic test_reset_midblock();
        logic [127:0] plain = 128'h0badf00d11223344aabbccdd99887766;
        loadWord(32'hffffffff, fillRnd(32'h01010101));
        loadWord(32'heeeeeeee, fillRnd(32'h02020202));
        loadWord(32'hdddddddd, fillRnd(32'h03030303));
        @(negedge clk);
        rnd_valid = 1'b1;
        #2 reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", out_valid); end
        total++; if (msk_out !== '0) begin bad++; $display("FAIL rst_mid_msk got=%h want=0", msk_out); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_in_ready got=%b want=0", in_ready); end
        rnd_valid = 1'b0;
        model = '0; kModel = 0;
        @(negedge clk);
        reset = 1'b1;
        loadWord(32'h0badf00d, fillRnd(32'h04040404));
        loadWord(32'h11223344, fillRnd(32'h05050505));
        loadWord(32'haabbccdd, fillRnd(32'h06060606));
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_wcnt_cleared got=%b want=0", out_valid); end
        loadWord(32'h99887766, fillRnd(32'h07070707));
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_reload_valid got=%b want=1", out_valid); end
        total++; if (msk_out !== model) begin bad++; $display("FAIL rst_reload_msk got=%h want=%h", msk_out, model); end
        total++; if (recombine(msk_out) !== plain) begin bad++; $display("FAIL rst_reload_recomb got=%h want=%h", recombine(msk_out), plain); end
        @(negedge clk);
        #3 reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_hold_valid got=%b want=0", out_valid); end
        model = '0; kModel = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

`ifdef MSK_REFRESH_EN
    task automatic test_refresh();
        logic [127:0] plain = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        logic [128*D-1:0] prev;
        logic [RW-1:0] rv;
        int ptr;
        loadWord(32'h0f1e2d3c, '1);
        loadWord(32'h4b5a6978, '1);
        loadWord(32'h8796a5b4, '1);
        loadWord(32'hc3d2e1f0, '1);
        ptr = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int j = 0; j < D - 1; j++) rv[32*j +: 32] = $urandom | 32'h1;
            rnd_valid = 1'b1; rnd = rv; out_ready = 1'b0;
            #1;
            total++; if (rnd_ready !== 1'b1) begin bad++; $display("FAIL refresh_rnd_ready c=%0d got=%b want=1", c, rnd_ready); end
            prev = msk_out;
            @(posedge clk);
            #1;
            model[WW*(3-ptr) +: WW] = model[WW*(3-ptr) +: WW] ^ encode(32'h0, rv);
            ptr = (ptr + 1) % 4;
            total++; if (msk_out === prev) begin bad++; $display("FAIL refresh_changed c=%0d got=%h want=changed", c, msk_out); end
            total++; if (msk_out !== model) begin bad++; $display("FAIL refresh_msk c=%0d got=%h want=%h", c, msk_out, model); end
            total++; if (recombine(msk_out) !== plain) begin bad++; $display("FAIL refresh_recomb c=%0d got=%h want=%h", c, recombine(msk_out), plain); end
        end
        rnd_valid = 1'b0;
        doHandshake();
    endtask
`else
    task automatic test_hold_stable();
        loadWord(32'h0f1e2d3c, fillRnd(32'h10203040));
        loadWord(32'h4b5a6978, fillRnd(32'h50607080));
        loadWord(32'h8796a5b4, fillRnd(32'h90a0b0c0));
        loadWord(32'hc3d2e1f0, fillRnd(32'hd0e0f000));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rnd_valid = 1'b1; rnd = fillRnd($urandom);
            #1;
            total++; if (rnd_ready !== 1'b0) begin bad++; $display("FAIL hold_rnd_ready c=%0d got=%b want=0", c, rnd_ready); end
            @(posedge clk);
            #1;
            total++; if (msk_out !== model) begin bad++; $display("FAIL hold_stable c=%0d got=%h want=%h", c, msk_out, model); end
        end
        rnd_valid = 1'b0;
        doHandshake();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_midblock();
`ifdef MSK_REFRESH_EN
        test_refresh();
`else
        test_hold_stable();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
